// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS32 MEM-stage data memory access unit:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - FSM state encoding for mem_access_unit
//   - default attached RAM depth in 32-bit words
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_STROBE,
        RD_CAPTURE,
        WR_SETUP,
        WR_STROBE,
        RESP
    } state_t;

    // Anything that is not a byte or half access is handled as a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size != SZ_BYTE) && (size != SZ_HALF);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational little-endian lane logic.
// Ports:
//   rd_word      in  32  word read from the data RAM
//   offset       in   2  byte offset (addr[1:0]); half uses offset[1] only
//   size         in   2  access size (SZ_BYTE / SZ_HALF / word)
//   is_unsigned  in   1  zero-extend loaded lane when 1
//   wdata        in  32  store data, right-justified
//   load_data    out 32  extracted and extended load result
//   merged_word  out 32  rd_word with the selected lane replaced by wdata
// -----------------------------------------------------------------------------
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        byte_val    = rd_word[{offset, 3'b000} +: 8];
        half_val    = offset[1] ? rd_word[31:16] : rd_word[15:0];
        load_data   = rd_word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data   = is_unsigned ? {24'h0, byte_val}
                                          : {{24{byte_val[7]}}, byte_val};
                merged_word = rd_word;
                merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data   = is_unsigned ? {16'h0, half_val}
                                          : {{16{half_val[15]}}, half_val};
                merged_word = rd_word;
                if (offset[1]) merged_word[31:16] = wdata[15:0];
                else           merged_word[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage initiator for the MIPS32 word-addressed data RAM. Accepts one
// load/store at a time and sequences the RAM strobes so that address and data
// are stable a full cycle before each single-cycle strobe, strobes never
// overlap and never occur in consecutive cycles. Sub-word stores are done as
// read-modify-write.
// Optional build macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests skip the RAM and respond next cycle with misalign_err;
// when undefined, the offending low address bits are ignored.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write/req_size/req_unsigned  store flag, access size, zero-extend flag
//   req_addr/req_wdata               byte address, right-justified store data
//   resp_valid/resp_rdata            completion pulse, extended load data
//   misalign_err                     misaligned-access flag with resp_valid
//   mem_address/mem_data_in          RAM word index and write data
//   mem_write_enable/mem_read_enable RAM strobes
//   mem_data_out                     RAM read data
// -----------------------------------------------------------------------------
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_data_out
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_t      state;
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;      // only the sub-word lanes are needed for merge
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        trap_hit;

    assign req_ready = (state == IDLE);

    // Addresses beyond the RAM silently wrap: upper index bits are dropped.
    if (IDX_W < 30) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[31:IDX_W+2];
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_hit = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));

    // Set only for the single RESP cycle of a trapped request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= req_valid && (state == IDLE) && trap_hit;
    end
`else
    assign trap_hit     = 1'b0;
    assign misalign_err = 1'b0;
`endif

    mem_lane_align u_lane (
        .rd_word     (mem_data_out),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       ({16'h0, wdata_q}),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            write_q          <= 1'b0;
            unsigned_q       <= 1'b0;
            size_q           <= SZ_BYTE;
            offset_q         <= 2'b00;
            wdata_q          <= 16'h0;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'h0;
            mem_address      <= 32'h0;
            mem_data_in      <= 32'h0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from pre-edge values regardless of statement order.
            // Pulses default low; each state raises at most one of them.
            resp_valid       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        unsigned_q  <= req_unsigned;
                        size_q      <= req_size;
                        offset_q    <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        mem_address <= {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
                        if (trap_hit) begin
                            resp_rdata <= 32'h0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_write && is_word(req_size)) begin
                            mem_data_in <= req_wdata;
                            state       <= WR_SETUP;
                        end else begin
                            state <= RD_SETUP;
                        end
                    end
                end
                RD_SETUP: begin
                    mem_read_enable <= 1'b1;
                    state           <= RD_STROBE;
                end
                RD_STROBE: state <= RD_CAPTURE;
                RD_CAPTURE: begin
                    // RAM data is valid this cycle; either finish the load or
                    // stage the merged word for the write half of the RMW.
                    if (write_q) begin
                        mem_data_in <= merged_word;
                        state       <= WR_SETUP;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR_SETUP: begin
                    mem_write_enable <= 1'b1;
                    state            <= WR_STROBE;
                end
                WR_STROBE: begin
                    resp_rdata <= 32'h0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit with a behavioural
// enable-edge-triggered 32-word RAM and a strobe-discipline monitor.
// Honours MEM_MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_data_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int viol_cnt = 0;

    mem_access_unit #(.MEM_WORDS(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .misalign_err     (misalign_err),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (enable-edge triggered) ----------------
    logic [31:0] ram [0:31];
    logic        pk_en = 1'b0;
    logic [4:0]  pk_a = '0;
    logic [31:0] pk_d = '0;

    always @(posedge clk) begin
        if (pk_en) ram[pk_a] <= pk_d;
        if (mem_write_enable) ram[mem_address[4:0]] <= mem_data_in;
        if (mem_read_enable) mem_data_out <= ram[mem_address[4:0]];
    end

    // ---------------- strobe discipline monitor ----------------
    logic        prev_re, prev_we;
    logic [31:0] prev_addr, prev_din;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_re = 1'b0;
            prev_we = 1'b0;
        end else begin
            if (mem_read_enable && mem_write_enable) viol_cnt++;
            if ((mem_read_enable || mem_write_enable) && (prev_re || prev_we)) viol_cnt++;
            if ((mem_read_enable || mem_write_enable) && (mem_address !== prev_addr)) viol_cnt++;
            if (mem_write_enable && (mem_data_in !== prev_din)) viol_cnt++;
            prev_re = mem_read_enable;
            prev_we = mem_write_enable;
        end
        prev_addr = mem_address;
        prev_din  = mem_data_in;
    end

    // ---------------- per-cycle samples of one transaction ----------------
    logic        s_rv  [1:8];
    logic        s_re  [1:8];
    logic        s_we  [1:8];
    logic        s_me  [1:8];
    logic        s_rdy [1:8];
    logic [31:0] s_ma  [1:8];
    logic [31:0] s_rd  [1:8];

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total_cnt++;
            $display("FAIL wait_idle: req_ready never rose within 20 cycles");
        end
    endtask

    // Drives one request at a negedge while idle; the following posedge is
    // cycle 0 and samples are taken at the negedge of cycles 1..8.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic hold);
        wait_idle();
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = 32'hFFFF_FFFF;
            req_wdata = 32'h5555_5555;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s_rv[c] = resp_valid;      s_re[c] = mem_read_enable;
            s_we[c] = mem_write_enable; s_me[c] = misalign_err;
            s_rdy[c] = req_ready;      s_ma[c] = mem_address;
            s_rd[c] = resp_rdata;
            if (hold && c == 6) req_valid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({resp_valid, mem_read_enable, mem_write_enable, misalign_err} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {resp_valid, mem_read_enable, mem_write_enable, misalign_err});
        else pass_cnt++;
        total_cnt++;
        if ({resp_rdata, mem_address, mem_data_in} !== 96'h0)
            $display("FAIL reset_data: rdata=%h addr=%h din=%h expected all 0",
                     resp_rdata, mem_address, mem_data_in);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_word_store();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        total_cnt++;
        if (s_ma[1] !== 32'd4) $display("FAIL sw_addr: got %h expected 4", s_ma[1]);
        else pass_cnt++;
        total_cnt++;
        if ({s_we[1], s_we[2], s_we[3], s_re[2]} !== 4'b0100)
            $display("FAIL sw_strobe: we1..3,re2=%b expected 0100", {s_we[1], s_we[2], s_we[3], s_re[2]});
        else pass_cnt++;
        total_cnt++;
        if ({s_rv[2], s_rv[3], s_rv[4], s_rdy[3], s_rdy[4]} !== 5'b01001)
            $display("FAIL sw_resp: rv2..4,rdy3,rdy4=%b expected 01001",
                     {s_rv[2], s_rv[3], s_rv[4], s_rdy[3], s_rdy[4]});
        else pass_cnt++;
        total_cnt++;
        if (ram[4] !== 32'hDEADBEEF) $display("FAIL sw_ram: got %h expected deadbeef", ram[4]);
        else pass_cnt++;
    endtask

    task automatic test_word_load();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        total_cnt++;
        if ({s_re[1], s_re[2], s_re[3], s_we[2]} !== 4'b0100)
            $display("FAIL lw_strobe: re1..3,we2=%b expected 0100", {s_re[1], s_re[2], s_re[3], s_we[2]});
        else pass_cnt++;
        total_cnt++;
        if ({s_rv[3], s_rv[4], s_rv[5], s_rdy[4], s_rdy[5]} !== 5'b01001)
            $display("FAIL lw_resp: rv3..5,rdy4,rdy5=%b expected 01001",
                     {s_rv[3], s_rv[4], s_rv[5], s_rdy[4], s_rdy[5]});
        else pass_cnt++;
        total_cnt++;
        if (s_rd[4] !== 32'hDEADBEEF) $display("FAIL lw_data: got %h expected deadbeef", s_rd[4]);
        else pass_cnt++;
        total_cnt++;
        if (s_rd[8] !== 32'hDEADBEEF) $display("FAIL lw_hold: got %h expected deadbeef", s_rd[8]);
        else pass_cnt++;
    endtask

    task automatic test_load_extend();
        string       nm [6];
        logic [1:0]  sz [6];
        logic        us [6];
        logic [31:0] ad [6];
        logic [31:0] ex [6];
        nm = '{"lb3", "lbu3", "lh2", "lhu0", "lb1", "lh0"};
        sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        us = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ad = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
               32'h0000007F, 32'h00007F01};
        poke(5'd0, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, sz[i], us[i], ad[i], 32'h0, 1'b0);
            total_cnt++;
            if (s_rv[4] !== 1'b1 || s_rd[4] !== ex[i])
                $display("FAIL ext_%s: rv=%b rdata=%h expected rv=1 rdata=%h",
                         nm[i], s_rv[4], s_rd[4], ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_subword_store();
        poke(5'd1, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h123456AA, 1'b0);
        total_cnt++;
        if ({s_re[2], s_we[2], s_re[5], s_we[5], s_we[4], s_we[6]} !== 6'b100100)
            $display("FAIL sb_strobe: re2,we2,re5,we5,we4,we6=%b expected 100100",
                     {s_re[2], s_we[2], s_re[5], s_we[5], s_we[4], s_we[6]});
        else pass_cnt++;
        total_cnt++;
        if ({s_rv[4], s_rv[5], s_rv[6], s_rdy[6], s_rdy[7]} !== 5'b00101)
            $display("FAIL sb_resp: rv4..6,rdy6,rdy7=%b expected 00101",
                     {s_rv[4], s_rv[5], s_rv[6], s_rdy[6], s_rdy[7]});
        else pass_cnt++;
        total_cnt++;
        if (ram[1] !== 32'h1122AA44 || s_rd[6] !== 32'h0)
            $display("FAIL sb_merge: ram=%h rdata=%h expected 1122aa44 / 0", ram[1], s_rd[6]);
        else pass_cnt++;
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'hCAFEBEEF, 1'b0);
        total_cnt++;
        if (ram[1] !== 32'hBEEFAA44 || s_rv[6] !== 1'b1)
            $display("FAIL sh_merge: ram=%h rv6=%b expected beefaa44 / 1", ram[1], s_rv[6]);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_hold();
        issue(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 1'b1);
        total_cnt++;
        if (s_ma[1] !== 32'd1) $display("FAIL wrap_addr: got %h expected 1", s_ma[1]);
        else pass_cnt++;
        total_cnt++;
        if (s_rd[4] !== 32'hBEEFAA44) $display("FAIL wrap_data: got %h expected beefaa44", s_rd[4]);
        else pass_cnt++;
        total_cnt++;
        if ({s_rdy[1], s_rdy[2], s_rdy[3], s_rdy[4], s_re[2], s_re[3], s_re[4]} !== 7'b0000100)
            $display("FAIL hold_busy: rdy1..4,re2..4=%b expected 0000100",
                     {s_rdy[1], s_rdy[2], s_rdy[3], s_rdy[4], s_re[2], s_re[3], s_re[4]});
        else pass_cnt++;
        total_cnt++;
        if ({s_rdy[5], s_rdy[6]} !== 2'b10)
            $display("FAIL hold_reaccept: rdy5,rdy6=%b expected 10", {s_rdy[5], s_rdy[6]});
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_misalign();
        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        total_cnt++;
        if ({s_rv[1], s_me[1], s_rdy[2], s_me[2]} !== 4'b1110 || s_rd[1] !== 32'h0)
            $display("FAIL trap_resp: rv1,me1,rdy2,me2=%b rdata=%h expected 1110 / 0",
                     {s_rv[1], s_me[1], s_rdy[2], s_me[2]}, s_rd[1]);
        else pass_cnt++;
        total_cnt++;
        if ((s_re[1] | s_re[2] | s_re[3] | s_we[1] | s_we[2] | s_we[3]) !== 1'b0)
            $display("FAIL trap_nostrobe: a strobe was seen, expected none");
        else pass_cnt++;
`else
        total_cnt++;
        if (s_ma[1] !== 32'd0 || s_rd[4] !== 32'h80FF7F01 || s_me[4] !== 1'b0)
            $display("FAIL align_lw: addr=%h rdata=%h err=%b expected 0 / 80ff7f01 / 0",
                     s_ma[1], s_rd[4], s_me[4]);
        else pass_cnt++;
        issue(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 1'b0);
        total_cnt++;
        if (s_rd[4] !== 32'h00007F01 || s_rv[4] !== 1'b1)
            $display("FAIL align_lh: rdata=%h rv=%b expected 00007f01 / 1", s_rd[4], s_rv[4]);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_op();
        int rv_seen = 0;
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mem_read_enable !== 1'b1) $display("FAIL rst_pre: re=%b expected 1", mem_read_enable);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_read_enable !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL rst_drop: re=%b rv=%b expected 0 0", mem_read_enable, resp_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        total_cnt++;
        if (rv_seen != 0 || req_ready !== 1'b1)
            $display("FAIL rst_after: resp_valid pulses=%0d ready=%b expected 0 / 1", rv_seen, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_strobe_discipline();
        total_cnt++;
        if (viol_cnt != 0) $display("FAIL strobe_rules: violations=%0d expected 0", viol_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_word_load();
        test_load_extend();
        test_subword_store();
        test_wrap_and_hold();
        test_misalign();
        test_reset_mid_op();
        test_strobe_discipline();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the MIPS32 data memory: turns pipeline load/store requests into the strobe sequence the word-addressed data RAM expects.
- Handles byte/halfword/word access, read-modify-write for sub-word stores, and sign/zero extension of loads.
- Sits between the pipeline MEM stage and the data RAM instance; one request in flight at a time.

Parameters:
- MEM_WORDS, 32, depth of attached RAM in 32-bit words; word index truncated to $clog2(MEM_WORDS) bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  pipeline request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  input  1  load zero-extends when 1 (lbu/lhu)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores
- misalign_err  output  1  misaligned-access flag, valid with resp_valid
- mem_address  output  32  RAM word index, zero-extended
- mem_data_in  output  32  RAM write data
- mem_write_enable  output  1  RAM write strobe
- mem_read_enable  output  1  RAM read strobe
- mem_data_out  input  32  RAM read data

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready 1 once released; resp_valid, misalign_err, mem_write_enable, mem_read_enable 0; resp_rdata, mem_address, mem_data_in 0.
- Accept on rising edge with req_valid & req_ready (cycle 0); all request fields registered; inputs ignored afterwards.
- Strobe discipline (RAM is enable-edge triggered):
  - Address and data stable one full cycle before any strobe.
  - Each strobe high for exactly one cycle.
  - The two strobes are never high together.
  - Strobes are always low in the cycle after a strobe.
- States: IDLE, RD_SETUP, RD_STROBE, RD_CAPTURE, WR_SETUP, WR_STROBE, RESP.
- Word load:
  - Cycle 1 RD_SETUP: mem_address driven.
  - Cycle 2 RD_STROBE: mem_read_enable 1.
  - Cycle 3 RD_CAPTURE: mem_data_out latched at end of cycle.
  - Cycle 4 RESP: resp_valid 1.
- Byte/half load: same timing; lane extracted, then sign- or zero-extended.
- Word store:
  - Cycle 1 WR_SETUP: mem_address and mem_data_in driven.
  - Cycle 2 WR_STROBE: mem_write_enable 1.
  - Cycle 3 RESP.
- Sub-word store (read-modify-write):
  - Cycles 1-3: read sequence.
  - Cycle 4 WR_SETUP: merged word driven.
  - Cycle 5 WR_STROBE.
  - Cycle 6 RESP.
- After RESP: return to IDLE; req_ready rises cycle 7 / 5 / 4 for sub-word store / load / word store.
- Lanes (little-endian):
  - Byte offset = addr[1:0], bits [8*off+7:8*off].
  - Half uses addr[1]: 0 selects [15:0], 1 selects [31:16].
  - Merge replaces only the selected lane; other bytes are preserved from the read word.
- Word index = req_addr[31:2] truncated modulo MEM_WORDS. Addresses at or beyond the RAM range wrap silently.
- resp_rdata holds its value until the next RESP.
- Reset mid-operation:
  - Strobes drop immediately; no resp_valid; transaction abandoned.
  - A write strobe already risen has taken effect.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, performs no RAM access.
  - RESP follows in cycle 1 with misalign_err 1 and resp_rdata 0.
- Undefined:
  - Offending low address bits are ignored (forced alignment).
  - misalign_err is tied 0.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encodings;
  - the MEM_WORDS default.
- One combinational sub-module, mem_lane_align:
  - load extract + extend: (word, offset, size, unsigned) -> rdata;
  - store merge: (old word, wdata, offset, size) -> new word.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> write strobe cycle 2 with mem_address=4; load resp cycle 4 with rdata 0xDEADBEEF.
- Word 0x80FF7F01 @0x0: lb @0x3 -> 0xFFFFFF80; lbu @0x3 -> 0x00000080; lh @0x2 -> 0xFFFF80FF; lhu @0x0 -> 0x00007F01.
- sb 0xAA @0x5 over 0x11223344 -> read then write; word becomes 0x1122AA44; resp cycle 6; strobes never overlap and never back-to-back.
- req_addr 0x84 with MEM_WORDS=32 -> mem_address=1 (wrap); req_valid held high while busy -> no second accept until req_ready.
- rst_n low during RD_STROBE -> mem_read_enable 0 immediately, no resp_valid, req_ready 1 after release.
- With MEM_MISALIGN_TRAP_EN: lw @0x2 -> resp cycle 1, misalign_err 1, no strobes; without it: reads word index 0.
